// File: rtl/neuron_pkg.sv
// neuron_pkg: shared constants for the neuron MAC datapath.
// Holds the FSM state encoding, the drain length, and helpers that derive
// the fractional-bit count and the overflow-free accumulator width.
package neuron_pkg;

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;

    localparam int DRAIN_CYCLES = 3;

    // Q1.(DW-1) format: everything except the sign bit is fraction
    function automatic int frac_bits(input int data_width);
        return data_width - 1;
    endfunction

    // Full-precision product plus log2(N) guard bits so N products never overflow
    function automatic int acc_width(input int data_width, input int n_weight);
        return 2 * data_width + $clog2(n_weight);
    endfunction

endpackage

// File: rtl/fxp_saturate.sv
// fxp_saturate: arithmetic right shift (rounds toward -inf), clamp to the
// signed OUT_WIDTH range, and an optional ReLU.
// Build option: define NEURON_RELU_EN to force negative results to zero.
module fxp_saturate #(
    parameter int IN_WIDTH  = 40,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15
) (
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic [OUT_WIDTH-1:0] out_data
);

    localparam logic signed [IN_WIDTH-1:0] MAX_V =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] MIN_V =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [IN_WIDTH-1:0] in_s;
    logic signed [IN_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]       clamped;

    assign in_s    = in_data;
    assign shifted = in_s >>> SHIFT;

    // Clamp the rescaled sum into the representable output range
    always_comb begin
        clamped = shifted[OUT_WIDTH-1:0];
        if (shifted > MAX_V) begin
            clamped = MAX_V[OUT_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            clamped = MIN_V[OUT_WIDTH-1:0];
        end
    end

`ifdef NEURON_RELU_EN
    // ReLU: negative saturated values become zero
    always_comb begin
        out_data = clamped;
        if (clamped[OUT_WIDTH-1]) begin
            out_data = '0;
        end
    end
`else
    // Signed saturated value passes through unchanged
    always_comb begin
        out_data = clamped;
    end
`endif

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: weight-stationary multiply-accumulate stage.
// Accepts one Q1.15 sample per handshake, reads the matching weight from
// Weight_mem (1-cycle registered read), accumulates N_WEIGHT products at full
// precision, then emits one saturated output through a valid/ready handshake.
// Build option: NEURON_RELU_EN (handled in fxp_saturate) clamps negatives to 0.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int N_WEIGHT   = 256,
    parameter int DATA_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic                        w_ren,
    output logic [$clog2(N_WEIGHT)-1:0] w_radd,
    input  logic [DATA_WIDTH-1:0]       w_rdata,
    output logic [DATA_WIDTH-1:0]       dout,
    output logic                        dout_valid,
    input  logic                        dout_ready
);

    localparam int AW    = $clog2(N_WEIGHT);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = acc_width(DATA_WIDTH, N_WEIGHT);

    logic [1:0]                   state;
    logic [1:0]                   drain_cnt;
    logic [AW-1:0]                idx;
    logic signed [DATA_WIDTH-1:0] din_d;
    logic signed [DATA_WIDTH-1:0] w_s;
    logic signed [PW-1:0]         prod;
    logic signed [ACC_W-1:0]      acc;
    logic                         prod_v;
    logic                         acc_v;
    logic                         accept;
    logic                         last;
    logic                         out_done;
    logic [DATA_WIDTH-1:0]        sat_out;

    assign w_s      = w_rdata;
    assign accept   = din_valid && din_ready;
    assign last     = (idx == AW'(N_WEIGHT - 1));
    assign out_done = (state == OUT) && dout_valid && dout_ready;
    assign w_ren    = accept;
    assign w_radd   = idx;

    // Ready only while accumulating and never while held in reset
    always_comb begin
        din_ready = rst_n && (state == ACCUM);
    end

    fxp_saturate #(
        .IN_WIDTH  (ACC_W),
        .OUT_WIDTH (DATA_WIDTH),
        .SHIFT     (frac_bits(DATA_WIDTH))
    ) u_sat (
        .in_data  (acc),
        .out_data (sat_out)
    );

    // Sequencer: index walk, drain countdown and output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACCUM;
            idx        <= '0;
            drain_cnt  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            idx       <= '0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                        dout       <= sat_out;
                        dout_valid <= 1'b1;
                        state      <= OUT;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // Three-stage datapath: capture sample, multiply by weight, accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_d  <= '0;
            prod   <= '0;
            acc    <= '0;
            prod_v <= 1'b0;
            acc_v  <= 1'b0;
        end else begin
            if (accept) begin
                din_d <= din;
            end
            prod_v <= accept;
            if (prod_v) begin
                prod <= PW'(din_d) * PW'(w_s);
            end
            acc_v <= prod_v;
            if (out_done) begin
                acc <= '0;
            end else if (acc_v) begin
                acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed scoreboard bench for neuron_mac with N_WEIGHT=4 and
// a registered Weight_mem model preloaded with 0x4000 (0.5) everywhere.
module tb_neuron_mac;

    localparam int NW = 4;
    localparam int DW = 16;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          w_ren;
    logic [AW-1:0] w_radd;
    logic [DW-1:0] w_rdata;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int last_accept = 0;
    int hs_count   = 0;
    logic prev_valid = 1'b0;

    logic [DW-1:0] exp_q[$];
    int            lat_q[$];
    int            wlog[$];
    logic [DW-1:0] mem [NW];

`ifdef NEURON_RELU_EN
    localparam logic [DW-1:0] NEG_EXP = 16'h0000;
`else
    localparam logic [DW-1:0] NEG_EXP = 16'h8000;
`endif

    neuron_mac #(.N_WEIGHT(NW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .w_ren      (w_ren),
        .w_radd     (w_radd),
        .w_rdata    (w_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure output latency
    always @(posedge clk) cyc <= cyc + 1;

    // Weight_mem model: 1-cycle registered read, untouched by reset
    initial for (int i = 0; i < NW; i++) mem[i] = 16'h4000;
    always @(posedge clk) if (w_ren) w_rdata <= mem[w_radd];

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: logs weight reads and scores each new output against the queue
    always @(negedge clk) begin
        if (w_ren) wlog.push_back(int'(w_radd));
        if (rst_n && dout_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_output: got 0x%0h, expected none", dout);
            end else begin
                checkOutput("dout", int'(dout), int'(exp_q.pop_front()));
                checkOutput("latency", cyc - lat_q.pop_front(), 4);
            end
        end
        prev_valid <= rst_n && dout_valid;
        if (dout_valid && dout_ready) hs_count <= hs_count + 1;
    end

    // Offer one sample, wait (bounded) for its accept, then idle for gap cycles
    task automatic applyStimulus(input logic [DW-1:0] v, input int gap);
        int waited = 0;
        din       = v;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: got no accept, expected one within 100 cycles");
        end
        last_accept = cyc;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    task automatic runStream(input logic [DW-1:0] v, input int gap, input logic [DW-1:0] expv);
        for (int i = 0; i < NW; i++) applyStimulus(v, (i < NW - 1) ? gap : 0);
        exp_q.push_back(expv);
        lat_q.push_back(last_accept);
    endtask

    task automatic waitHandshake();
        int start = hs_count;
        int n = 0;
        while (hs_count == start && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL handshake_timeout: got none, expected one within 60 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_din_ready", int'(din_ready), 0);
        checkOutput("rst_w_ren", int'(w_ren), 0);
        checkOutput("rst_w_radd", int'(w_radd), 0);
        checkOutput("rst_dout", int'(dout), 0);
        checkOutput("rst_dout_valid", int'(dout_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_din_ready", int'(din_ready), 1);
        @(posedge clk);
        #1;

        // Back-to-back 0.25 x 0.5 x 4 = 0.5
        $display("[TB] stream 0x2000 back-to-back");
        runStream(16'h2000, 0, 16'h4000);
        waitHandshake();

        // 0.5 x 0.5 x 4 = 1.0 saturates positive
        $display("[TB] stream 0x4000 saturating");
        runStream(16'h4000, 0, 16'h7FFF);
        waitHandshake();

        // -0.5 x 0.5 x 4 = -1.0 (or 0 under ReLU)
        $display("[TB] stream 0xC000 negative");
        runStream(16'hC000, 0, NEG_EXP);
        waitHandshake();

        // Bubbles between samples must not alter the result
        $display("[TB] stream 0x2000 with bubbles");
        wlog.delete();
        runStream(16'h2000, 2, 16'h4000);
        checkOutput("bubble_wren_count", wlog.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput("bubble_w_radd", (i < wlog.size()) ? wlog[i] : -1, i);
        waitHandshake();

        // Backpressure: hold dout_ready low for 5 OUT cycles
        $display("[TB] backpressure hold");
        dout_ready = 1'b0;
        runStream(16'h2000, 0, 16'h4000);
        begin
            int n = 0;
            while (!dout_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            checkOutput("bp_valid_reached", int'(dout_valid), 1);
        end
        wlog.delete();
        din       = 16'h7FFF;
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_dout_stable", int'(dout), 16'h4000);
            checkOutput("bp_dout_valid", int'(dout_valid), 1);
            checkOutput("bp_din_ready", int'(din_ready), 0);
        end
        checkOutput("bp_ignored_wren", wlog.size(), 0);
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_release_din_ready", int'(din_ready), 1);
        checkOutput("bp_release_dout_valid", int'(dout_valid), 0);
        @(posedge clk);
        #1;
        wlog.delete();
        runStream(16'h4000, 0, 16'h7FFF);
        checkOutput("bp_next_first_addr", (wlog.size() > 0) ? wlog[0] : -1, 0);
        waitHandshake();

        // Reset mid-accumulation discards the partial sum
        $display("[TB] reset mid-stream");
        applyStimulus(16'h4000, 0);
        applyStimulus(16'h4000, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_din_ready", int'(din_ready), 0);
        checkOutput("mid_rst_w_ren", int'(w_ren), 0);
        checkOutput("mid_rst_w_radd", int'(w_radd), 0);
        checkOutput("mid_rst_dout", int'(dout), 0);
        checkOutput("mid_rst_dout_valid", int'(dout_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_release_ready", int'(din_ready), 1);
        checkOutput("mid_rst_idx", int'(w_radd), 0);
        @(posedge clk);
        #1;
        runStream(16'h2000, 0, 16'h4000);
        waitHandshake();

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
